// File: rtl/div_mc_pkg.sv
// div_mc_pkg: shared types for the multicycle divider issue/collect stage.
// Holds the FSM state encoding and the captured result bundle.
package div_mc_pkg;

    localparam int unsigned DIV_MC_WIDTH = 16;
    localparam int unsigned DIV_MC_QW = DIV_MC_WIDTH;
    localparam int unsigned DIV_MC_RW = DIV_MC_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } div_state_e;

    typedef struct packed {
        logic [DIV_MC_QW-1:0] quotient;
        logic [DIV_MC_RW-1:0] remainder;
        logic                 div_zero;
    } div_res_t;

endpackage

// File: rtl/div_mc_ctrl_divider.sv
// divider: purely combinational unsigned divide, meant to be timed as a
// multicycle path. Zero divisor yields all-ones quotient and dividend remainder.
module divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH/2-1:0] remainder
);

    localparam int unsigned RW = WIDTH / 2;

    // Guard the zero divisor so the datapath never produces unknowns.
    always_comb begin
        quotient  = '1;
        remainder = RW'(dividend);
        if (divisor != '0) begin
            quotient  = dividend / divisor;
            remainder = RW'(dividend % divisor);
        end
    end

endmodule

// File: rtl/div_mc_ctrl.sv
// div_mc_ctrl: holds divider operands for HOLD_CYCLES, then captures the result.
// Optional macro DIV_MC_ZERO_CHECK_EN short-circuits zero divisors to DONE.
module div_mc_ctrl
    import div_mc_pkg::*;
#(
    parameter  int unsigned WIDTH           = DIV_MC_WIDTH,
    parameter  int unsigned HOLD_CYCLES     = 4,
    localparam int unsigned QUOTIENT_WIDTH  = WIDTH,
    localparam int unsigned REMAINDER_WIDTH = WIDTH / 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_dividend,
    input  logic [WIDTH-1:0]           in_divisor,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [QUOTIENT_WIDTH-1:0]  out_quotient,
    output logic [REMAINDER_WIDTH-1:0] out_remainder,
    output logic                       out_div_zero,
    output logic                       busy
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("div_mc_ctrl: HOLD_CYCLES must be at least 1");
    end
    if (WIDTH != DIV_MC_WIDTH) begin : g_bad_width
        $error("div_mc_ctrl: WIDTH must match div_mc_pkg::DIV_MC_WIDTH");
    end

    div_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       dvd_q, dvd_d;
    logic [WIDTH-1:0]       dvs_q, dvs_d;
    div_res_t               res_q, res_d;
    logic                   vld_q, vld_d;

    logic [WIDTH-1:0]           div_quo;
    logic [REMAINDER_WIDTH-1:0] div_rem;

    divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .dividend (dvd_q),
        .divisor  (dvs_q),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    assign in_ready      = (state_q == IDLE) && !rst;
    assign busy          = (state_q != IDLE);
    assign out_valid     = vld_q;
    assign out_quotient  = res_q.quotient;
    assign out_remainder = res_q.remainder;
    assign out_div_zero  = res_q.div_zero;

    // Next-state: accept, count down the hold window, capture, deliver.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        vld_d   = vld_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    dvd_d   = in_dividend;
                    dvs_d   = in_divisor;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    state_d = WAIT;
`ifdef DIV_MC_ZERO_CHECK_EN
                    if (in_divisor == '0) begin
                        res_d.quotient  = '1;
                        res_d.remainder = in_dividend[REMAINDER_WIDTH-1:0];
                        res_d.div_zero  = 1'b1;
                        vld_d           = 1'b1;
                        state_d         = DONE;
                    end
`endif
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    res_d.quotient  = div_quo;
                    res_d.remainder = div_rem;
                    res_d.div_zero  = 1'b0;
                    vld_d           = 1'b1;
                    state_d         = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (vld_q && out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
        end
    end

endmodule
